// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state encoding, operand indices and default sizes for the
// rsa_mont host controller.
package rsa_pkg;

   localparam int RSA_WIDTH  = 2048;
   localparam int RSA_WORD_W = 32;

   localparam logic [1:0] MSG = 2'd0;
   localparam logic [1:0] EXP = 2'd1;
   localparam logic [1:0] MOD = 2'd2;

   typedef enum logic [2:0] {
      LOAD      = 3'd0,
      GO        = 3'd1,
      WAIT_DONE = 3'd2,
      UNLOAD    = 3'd3,
      DRAIN     = 3'd4
   } state_t;

endpackage

// File: rtl/rsa_word_unpack.sv
// rsa_word_unpack: serializes a width-bit value into word_w-bit words,
// least-significant first, over valid/ready with a last flag.
module rsa_word_unpack
   import rsa_pkg::*;
#(
   parameter int width  = RSA_WIDTH,
   parameter int word_w = RSA_WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [word_w-1:0] first_word,
   input  logic [width-1:0]  data,
   output logic              valid,
   input  logic              ready,
   output logic [word_w-1:0] word,
   output logic              last,
   output logic              done
);

   localparam int N     = width / word_w;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   logic [IDX_W-1:0]  idx_r;
   logic [IDX_W-1:0]  idx_nxt_s;
   logic              valid_r;
   logic              last_r;
   logic [word_w-1:0] word_r;
   logic              handshake_s;

   assign handshake_s = valid_r && ready;
   assign idx_nxt_s   = idx_r + IDX_W'(1'b1);
   assign done        = handshake_s && last_r;

   // first_word bypasses data so the first word is valid on the same edge data is captured upstream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_r   <= {IDX_W{1'b0}};
         valid_r <= 1'b0;
         last_r  <= 1'b0;
         word_r  <= {word_w{1'b0}};
      end else if (start) begin
         idx_r   <= {IDX_W{1'b0}};
         valid_r <= 1'b1;
         last_r  <= (N == 1);
         word_r  <= first_word;
      end else if (handshake_s) begin
         if (last_r) begin
            idx_r   <= {IDX_W{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            word_r  <= {word_w{1'b0}};
         end else begin
            idx_r   <= idx_nxt_s;
            last_r  <= (idx_nxt_s == IDX_W'(N - 1));
            word_r  <= data[idx_nxt_s*word_w +: word_w];
         end
      end
   end

   assign valid = valid_r;
   assign last  = last_r;
   assign word  = word_r;

endmodule

// File: rtl/rsa_host_ctrl.sv
// rsa_host_ctrl: packs streamed operands for rsa_mont, runs its go/done
// handshake and streams the result back. Define RSA_HOST_TIMEOUT_EN for the core watchdog and err output.
module rsa_host_ctrl
   import rsa_pkg::*;
#(
   parameter int width          = RSA_WIDTH,
   parameter int word_w         = RSA_WORD_W,
   parameter int timeout_cycles = 2**24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [word_w-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [word_w-1:0] rd_data,
   output logic              rd_last,
   output logic              busy,
`ifdef RSA_HOST_TIMEOUT_EN
   output logic              err,
`endif
   output logic              core_go,
   input  logic              core_done,
   output logic [width-1:0]  core_message,
   output logic [width-1:0]  core_exponent,
   output logic [width-1:0]  core_modulus,
   input  logic [width-1:0]  core_cypher
);

   localparam int N     = width / word_w;
   localparam int CNT_W = $clog2(3 * N + 1);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   generate
      if ((width % word_w) != 0) begin : g_bad_width
         $error("rsa_host_ctrl: width must be a multiple of word_w");
      end
      if (timeout_cycles < 1) begin : g_bad_timeout
         $error("rsa_host_ctrl: timeout_cycles must be positive");
      end
   endgenerate

   state_t            state_r;
   state_t            state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [1:0]        op_r;
   logic [IDX_W-1:0]  widx_r;
   logic [width-1:0]  message_r;
   logic [width-1:0]  exponent_r;
   logic [width-1:0]  modulus_r;
   logic [width-1:0]  result_r;
   logic [width-1:0]  result_load_s;
   logic              core_go_r;
   logic              wr_ready_r;
   logic              accept_s;
   logic              last_word_s;
   logic              go_start_s;
   logic              finish_s;
   logic              timeout_s;
   logic              unpack_done_s;

   assign accept_s    = wr_valid && (state_r == LOAD);
   assign last_word_s = (cnt_r == CNT_W'(3 * N - 1));
   assign go_start_s  = accept_s && last_word_s;
   assign finish_s    = (state_r == WAIT_DONE) && (core_done || timeout_s);

`ifdef RSA_HOST_TIMEOUT_EN
   localparam int TMO_W = $clog2(timeout_cycles + 1);

   logic [TMO_W-1:0] tmo_r;
   logic             err_r;

   assign timeout_s = (state_r == WAIT_DONE) && !core_done &&
                      (tmo_r == TMO_W'(timeout_cycles - 1));

   // Watchdog: counts WAIT_DONE cycles; err holds until the next job starts loading.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_r <= {TMO_W{1'b0}};
         err_r <= 1'b0;
      end else begin
         if (go_start_s)
            tmo_r <= {TMO_W{1'b0}};
         else if (state_r == WAIT_DONE)
            tmo_r <= tmo_r + TMO_W'(1'b1);
         if (timeout_s)
            err_r <= 1'b1;
         else if (accept_s)
            err_r <= 1'b0;
      end
   end

   assign err = err_r;
`else
   assign timeout_s = 1'b0;
`endif

   // Result source: the core's answer, or all-ones when the watchdog fires.
   always_comb begin
      result_load_s = core_cypher;
      if (timeout_s)
         result_load_s = {width{1'b1}};
      else
         result_load_s = core_cypher;
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         LOAD: begin
            if (go_start_s) state_nxt_s = GO;
            else            state_nxt_s = LOAD;
         end
         GO:        state_nxt_s = WAIT_DONE;
         WAIT_DONE: begin
            if (finish_s) state_nxt_s = UNLOAD;
            else          state_nxt_s = WAIT_DONE;
         end
         UNLOAD: begin
            if (unpack_done_s) state_nxt_s = DRAIN;
            else               state_nxt_s = UNLOAD;
         end
         DRAIN: begin
            if (!core_done) state_nxt_s = LOAD;
            else            state_nxt_s = DRAIN;
         end
         default:   state_nxt_s = LOAD;
      endcase
   end

   // State, handshake outputs and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= LOAD;
         wr_ready_r <= 1'b1;
         core_go_r  <= 1'b0;
         result_r   <= {width{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         wr_ready_r <= (state_nxt_s == LOAD);
         if (go_start_s)
            core_go_r <= 1'b1;
         else if (finish_s)
            core_go_r <= 1'b0;
         if (finish_s)
            result_r <= result_load_s;
      end
   end

   // Operand packing: word k of the current operand lands at bits [k*word_w +: word_w].
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r      <= {CNT_W{1'b0}};
         op_r       <= MSG;
         widx_r     <= {IDX_W{1'b0}};
         message_r  <= {width{1'b0}};
         exponent_r <= {width{1'b0}};
         modulus_r  <= {width{1'b0}};
      end else if (accept_s) begin
         case (op_r)
            MSG:     message_r[widx_r*word_w +: word_w]  <= wr_data;
            EXP:     exponent_r[widx_r*word_w +: word_w] <= wr_data;
            MOD:     modulus_r[widx_r*word_w +: word_w]  <= wr_data;
            default: message_r <= message_r;
         endcase
         if (last_word_s) begin
            cnt_r  <= {CNT_W{1'b0}};
            op_r   <= MSG;
            widx_r <= {IDX_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
            if (widx_r == IDX_W'(N - 1)) begin
               widx_r <= {IDX_W{1'b0}};
               op_r   <= op_r + 2'd1;
            end else begin
               widx_r <= widx_r + IDX_W'(1'b1);
            end
         end
      end
   end

   rsa_word_unpack #(
      .width  (width),
      .word_w (word_w)
   ) u_unpack (
      .clk        (clk),
      .rst        (rst),
      .start      (finish_s),
      .first_word (result_load_s[word_w-1:0]),
      .data       (result_r),
      .valid      (rd_valid),
      .ready      (rd_ready),
      .word       (rd_data),
      .last       (rd_last),
      .done       (unpack_done_s)
   );

   assign wr_ready      = wr_ready_r;
   assign core_go       = core_go_r;
   assign busy          = (state_r != LOAD) || (cnt_r != {CNT_W{1'b0}});
   assign core_message  = message_r;
   assign core_exponent = exponent_r;
   assign core_modulus  = modulus_r;

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// tb_rsa_host_ctrl: scoreboard bench for rsa_host_ctrl with width=32, word_w=8
// and a behavioural rsa_mont model.
module tb_rsa_host_ctrl;

   localparam int W  = 32;
   localparam int WW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_valid;
   logic          wr_ready;
   logic [WW-1:0] wr_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [WW-1:0] rd_data;
   logic          rd_last;
   logic          busy;
   logic          core_go;
   logic          core_done;
   logic [W-1:0]  core_message;
   logic [W-1:0]  core_exponent;
   logic [W-1:0]  core_modulus;
   logic [W-1:0]  core_cypher;
`ifdef RSA_HOST_TIMEOUT_EN
   logic          err;
   logic          err_after_first;
`endif

   int total = 0;
   int bad   = 0;
   int hs_cnt = 0;
   logic [8:0] exp_q[$];
   logic       stall_prev = 1'b0;
   logic [WW-1:0] stall_word = 8'h00;

   int core_delay = 3;
   int hold_extra = 0;
   bit core_mute  = 1'b0;
   int go_cnt;
   int hold_left;

   always #5 clk = ~clk;

   rsa_host_ctrl #(
      .width          (W),
      .word_w         (WW),
      .timeout_cycles (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_data       (wr_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_data       (rd_data),
      .rd_last       (rd_last),
      .busy          (busy),
`ifdef RSA_HOST_TIMEOUT_EN
      .err           (err),
`endif
      .core_go       (core_go),
      .core_done     (core_done),
      .core_message  (core_message),
      .core_exponent (core_exponent),
      .core_modulus  (core_modulus),
      .core_cypher   (core_cypher)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                          input logic [31:0] n);
      logic [63:0] r;
      logic [63:0] x;
      logic [31:0] ee;
      if (n == 32'd0) return 32'd0;
      r  = 64'd1 % {32'd0, n};
      x  = {32'd0, b} % {32'd0, n};
      ee = e;
      while (ee != 32'd0) begin
         if (ee[0]) r = (r * x) % {32'd0, n};
         x  = (x * x) % {32'd0, n};
         ee = ee >> 1;
      end
      return r[31:0];
   endfunction

   // rsa_mont model: done after core_delay go cycles, held while go is high,
   // cleared hold_extra+1 cycles after go falls.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         core_done   <= 1'b0;
         core_cypher <= 32'd0;
         go_cnt      <= 0;
         hold_left   <= 0;
      end else if (core_go) begin
         if (!core_done && !core_mute) begin
            if (go_cnt >= core_delay) begin
               core_done   <= 1'b1;
               core_cypher <= modexp(core_message, core_exponent, core_modulus);
               hold_left   <= hold_extra;
            end else begin
               go_cnt <= go_cnt + 1;
            end
         end
      end else begin
         go_cnt <= 0;
         if (core_done) begin
            if (hold_left == 0) core_done <= 1'b0;
            else                hold_left <= hold_left - 1;
         end
      end
   end

   // Output monitor: scoreboard pop on each handshake, stability check across stalls.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev)
            chk("stall_hold", {55'd0, rd_valid, rd_data}, {55'd0, 1'b1, stall_word});
         stall_prev <= rd_valid && !rd_ready;
         stall_word <= rd_data;
         if (rd_valid && rd_ready) begin
            hs_cnt <= hs_cnt + 1;
            if (exp_q.size() == 0)
               chk("sb_empty", 64'(exp_q.size()), 64'd1);
            else
               chk("rd_word", {55'd0, rd_last, rd_data}, {55'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic put_word(input logic [WW-1:0] d);
      int n = 0;
      wr_valid = 1'b1;
      wr_data  = d;
      @(negedge clk);
      while (!wr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!wr_ready) chk("wr_accept", {63'd0, wr_ready}, 64'd1);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic send_job(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n);
      logic [31:0] ops [3];
      ops[0] = m;
      ops[1] = e;
      ops[2] = n;
      for (int o = 0; o < 3; o++) begin
         for (int k = 0; k < 4; k++) begin
            put_word(ops[o][k*8 +: 8]);
            if (o == 0 && k == 0) begin
               chk("busy_loading", {63'd0, busy}, 64'd1);
`ifdef RSA_HOST_TIMEOUT_EN
               err_after_first = err;
`endif
            end
            if (o == 2 && k == 2) chk("go_early", {63'd0, core_go}, 64'd0);
         end
      end
      chk("go_rise", {63'd0, core_go}, 64'd1);
      chk("msg", {32'd0, core_message}, {32'd0, m});
      chk("exp", {32'd0, core_exponent}, {32'd0, e});
      chk("mod", {32'd0, core_modulus}, {32'd0, n});
   endtask

   task automatic expect_result(input logic [31:0] r);
      for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), r[k*8 +: 8]});
   endtask

   task automatic wait_rd();
      int n = 0;
      while (!rd_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("rd_valid_seen", {63'd0, rd_valid}, 64'd1);
   endtask

   task automatic unload(input logic [15:0] pat);
      int i = 0;
      int start = hs_cnt;
      while ((hs_cnt - start) < 4 && i < 200) begin
         rd_ready = pat[i % 16];
         @(posedge clk);
         #1;
         i++;
      end
      rd_ready = 1'b0;
      chk("hs_count", 64'(hs_cnt - start), 64'd4);
      chk("sb_left", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_load();
      int n = 0;
      while (!wr_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("load_ready", {63'd0, wr_ready}, 64'd1);
   endtask

   task automatic run_job(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n,
                          input logic [31:0] r, input logic [15:0] pat);
      send_job(m, e, n);
      expect_result(r);
      wait_rd();
      unload(pat);
      wait_load();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int c;
      int hc;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      rd_ready = 1'b0;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
      chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
      chk("rst_rd_last",  {63'd0, rd_last},  64'd0);
      chk("rst_rd_data",  {56'd0, rd_data},  64'd0);
      chk("rst_core_go",  {63'd0, core_go},  64'd0);
      chk("rst_busy",     {63'd0, busy},     64'd0);
      chk("rst_msg",      {32'd0, core_message}, 64'd0);
      chk("rst_mod",      {32'd0, core_modulus}, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 4^13 mod 497 = 445 at full read rate
      run_job(32'd4, 32'd13, 32'd497, 32'd445, 16'hFFFF);

      // read stalls with rd_ready 1,0,0,1 and distinct bytes
      run_job(32'h01020304, 32'd1, 32'hFFFFFFFF, 32'h01020304, 16'h9999);

      // long done hold after go falls: DRAIN must wait for done low
      hold_extra = 9;
      send_job(32'd7, 32'd5, 32'd1009);
      expect_result(32'd663);
      wait_rd();
      unload(16'hFFFF);
      c  = 0;
      hc = 0;
      while (!wr_ready && c < 60) begin
         if (core_done) hc++;
         @(posedge clk);
         #1;
         c++;
      end
      chk("drain_exit", 64'(c), 64'(hc + 1));
      chk("drain_held", {63'd0, (hc >= 5)}, 64'd1);
      hold_extra = 0;
      run_job(32'd3, 32'd7, 32'd1000, 32'd187, 16'hFFFF);

      // reset while waiting for the core
      send_job(32'd5, 32'd3, 32'd100);
      @(posedge clk);
      #1;
      chk("go_waiting", {63'd0, core_go}, 64'd1);
      rst = 1'b1;
      #1;
      chk("abort_go",       {63'd0, core_go},  64'd0);
      chk("abort_rd_valid", {63'd0, rd_valid}, 64'd0);
      chk("abort_wr_ready", {63'd0, wr_ready}, 64'd1);
      chk("abort_busy",     {63'd0, busy},     64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_job(32'd5, 32'd3, 32'd100, 32'd25, 16'hFFFF);

      // writes during WAIT_DONE must be ignored
      core_delay = 8;
      send_job(32'd9, 32'd2, 32'd50);
      @(posedge clk);
      #1;
      wr_valid = 1'b1;
      wr_data  = 8'hFF;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      wr_valid = 1'b0;
      chk("ign_msg", {32'd0, core_message},  64'd9);
      chk("ign_exp", {32'd0, core_exponent}, 64'd2);
      chk("ign_mod", {32'd0, core_modulus},  64'd50);
      chk("ign_go",  {63'd0, core_go},       64'd1);
      chk("ign_rdy", {63'd0, wr_ready},      64'd0);
      expect_result(32'd31);
      wait_rd();
      unload(16'hFFFF);
      wait_load();
      core_delay = 3;

`ifdef RSA_HOST_TIMEOUT_EN
      // silent core: watchdog returns all-ones and flags err
      core_mute = 1'b1;
      send_job(32'd4, 32'd13, 32'd497);
      c = 0;
      while (core_go && c < 100) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk("tmo_go_cycles", 64'(c), 64'd17);
      chk("tmo_err_set", {63'd0, err}, 64'd1);
      expect_result(32'hFFFFFFFF);
      wait_rd();
      unload(16'hFFFF);
      wait_load();
      chk("tmo_err_hold", {63'd0, err}, 64'd1);
      core_mute = 1'b0;
      run_job(32'd4, 32'd13, 32'd497, 32'd445, 16'hFFFF);
      chk("tmo_err_clear", {63'd0, err_after_first}, 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
